// File: rtl/cia_serial_pkg.sv
// Shared types and constants for the CIA serial-port peer.
// Counter widths are derived from the cycle counts they must reach.
package cia_serial_pkg;

    localparam int unsigned BITS_PER_BYTE = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOW,
        TX_HIGH,
        TX_GAP
    } tx_state_t;

    // Width of a counter that runs 0 .. n-1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cia_sp_rx_shifter.sv
// Receive side of the serial peer: samples SP on each falling CNT from the CIA,
// assembles bytes MSB first and runs the rx_valid/rx_ready handshake.
module cia_sp_rx_shifter
    import cia_serial_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       enable,
    input  logic       sp_in,
    input  logic       cnt_in,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_overrun,
    output logic       rx_active
);

    localparam int unsigned IW = cnt_width(TIMEOUT);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

    logic          cnt_s;
    logic          cnt_d;
    logic          sp_s;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic [IW-1:0] idle_cnt;
    logic          fall;
    logic          done;
    logic          timeout;

    // SP is registered alongside CNT so the sampled bit is the one present at the pin edge.
    assign fall      = enable & cnt_d & ~cnt_s;
    assign done      = fall & (bit_cnt == 3'(BITS_PER_BYTE - 1));
    assign timeout   = enable & ~fall & (bit_cnt != 3'd0) & (idle_cnt == IDLE_LAST);
    assign rx_active = (bit_cnt != 3'd0);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cnt_s      <= 1'b1;
            cnt_d      <= 1'b1;
            sp_s       <= 1'b1;
            shreg      <= '0;
            bit_cnt    <= '0;
            idle_cnt   <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            cnt_s      <= cnt_in;
            cnt_d      <= cnt_s;
            sp_s       <= sp_in;
            rx_overrun <= done & rx_valid & ~rx_ready;

            if (done) begin
                rx_data  <= {shreg[6:0], sp_s};
                rx_valid <= 1'b1;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (!enable || timeout) begin
                shreg    <= '0;
                bit_cnt  <= '0;
                idle_cnt <= '0;
            end else if (fall) begin
                shreg    <= {shreg[6:0], sp_s};
                bit_cnt  <= bit_cnt + 3'd1;
                idle_cnt <= '0;
            end else if (bit_cnt != 3'd0) begin
                idle_cnt <= idle_cnt + 1'b1;
            end else begin
                idle_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/cia_serial_peer.sv
// External partner for the CIA serial port: transmits bytes as CNT/SP into a CIA
// in input mode, or receives bytes clocked out by a CIA in output mode.
module cia_serial_peer
    import cia_serial_pkg::*;
#(
    parameter int unsigned HALF    = 8,
    parameter int unsigned GAP     = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       tx_mode,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_overrun,
    output logic       busy,
    input  logic       sp_in,
    input  logic       cnt_in,
    output logic       sp_out,
    output logic       cnt_out
);

    localparam int unsigned TW = cnt_width((HALF > GAP) ? HALF : GAP);
    localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP - 1);

    tx_state_t     state;
    tx_state_t     state_nx;
    logic [TW-1:0] tmr;
    logic [TW-1:0] tmr_nx;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_cnt_nx;
    logic [7:0]    sh;
    logic [7:0]    sh_nx;
    logic          tx_ready_q;
    logic          accept;
    logic          rx_active;

    assign accept = tx_mode & tx_valid & tx_ready_q;

    always_comb begin
        state_nx   = state;
        tmr_nx     = tmr;
        bit_cnt_nx = bit_cnt;
        sh_nx      = sh;
        if (!tx_mode) begin
            state_nx   = TX_IDLE;
            tmr_nx     = '0;
            bit_cnt_nx = '0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (accept) begin
                        state_nx   = TX_LOW;
                        sh_nx      = tx_data;
                        bit_cnt_nx = '0;
                        tmr_nx     = '0;
                    end
                end
                TX_LOW: begin
                    if (tmr == HALF_LAST) begin
                        state_nx = TX_HIGH;
                        tmr_nx   = '0;
                    end else begin
                        tmr_nx = tmr + 1'b1;
                    end
                end
                TX_HIGH: begin
                    if (tmr == HALF_LAST) begin
                        tmr_nx = '0;
                        // The last bit is not shifted out so SP keeps it through GAP and IDLE.
                        if (bit_cnt == 3'(BITS_PER_BYTE - 1)) begin
                            state_nx = TX_GAP;
                        end else begin
                            state_nx   = TX_LOW;
                            bit_cnt_nx = bit_cnt + 3'd1;
                            sh_nx      = {sh[6:0], 1'b0};
                        end
                    end else begin
                        tmr_nx = tmr + 1'b1;
                    end
                end
                TX_GAP: begin
                    if (tmr == GAP_LAST) begin
                        state_nx = TX_IDLE;
                        tmr_nx   = '0;
                    end else begin
                        tmr_nx = tmr + 1'b1;
                    end
                end
                default: state_nx = TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state      <= TX_IDLE;
            tmr        <= '0;
            bit_cnt    <= '0;
            sh         <= '1;
            tx_ready_q <= 1'b0;
        end else begin
            state      <= state_nx;
            tmr        <= tmr_nx;
            bit_cnt    <= bit_cnt_nx;
            sh         <= sh_nx;
            tx_ready_q <= tx_mode & (state == TX_IDLE) & ~accept;
        end
    end

    cia_sp_rx_shifter #(
        .TIMEOUT (TIMEOUT)
    ) u_rx (
        .clk        (clk),
        .res_n      (res_n),
        .enable     (~tx_mode),
        .sp_in      (sp_in),
        .cnt_in     (cnt_in),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_overrun (rx_overrun),
        .rx_active  (rx_active)
    );

    // Outside tx_mode the pins idle high so the CIA can drive the line pair.
    assign tx_ready = tx_ready_q & tx_mode;
    assign cnt_out  = ~(tx_mode & (state == TX_LOW));
    assign sp_out   = ~tx_mode | sh[7];
    assign busy     = (state != TX_IDLE) | rx_active;

endmodule

// File: doc/cia_serial_peer.md
# cia_serial_peer

External partner for the CIA serial port: drives or receives the SP/CNT pair from outside the chip. In `tx_mode` it generates CNT clocks and SP data into a CIA in serial-input mode (CRA[6]=0). Otherwise it samples SP on CIA-generated CNT into a byte buffer (CIA in serial-output mode, CRA[6]=1). It sits in the board/peripheral layer beside the CIA, on the same system clock, and is the stimulus/response model and real device port for SDR traffic and ICR bit 3 behaviour.

## Interface
- `HALF`, 8: clk cycles per CNT half-period when transmitting (≥2).
- `GAP`, 16: clk cycles CNT held high after a transmitted byte before the next can start (≥1).
- `TIMEOUT`, 1024: clk cycles without a CNT falling edge after which a partial received byte is discarded.

- `clk` in 1: system clock, all logic on rising edge.
- `res_n` in 1: reset, asynchronous, active-low.
- `tx_mode` in 1: 1 = peer drives CNT/SP; 0 = peer receives.
- `tx_data` in 8: byte to send, MSB first.
- `tx_valid` in 1: byte offered.
- `tx_ready` out 1: peer accepts `tx_data` this cycle.
- `rx_data` out 8: last complete received byte.
- `rx_valid` out 1: `rx_data` holds an unconsumed byte.
- `rx_ready` in 1: consumer takes `rx_data`.
- `rx_overrun` out 1: one-cycle pulse when an unconsumed byte is overwritten.
- `busy` out 1: a byte is in flight (either direction).
- `sp_in` in 1: from CIA `sp_out`.
- `cnt_in` in 1: from CIA `cnt_out`.
- `sp_out` out 1: to CIA `sp_in`.
- `cnt_out` out 1: to CIA `cnt_in`.

## Operation
- Reset values:
  - `sp_out`=1, `cnt_out`=1.
  - `tx_ready`=0, `rx_valid`=0, `rx_data`=0x00, `rx_overrun`=0, `busy`=0.
  - State IDLE, all counters 0.
- TX FSM: IDLE → LOW → HIGH → (LOW … ) → GAP → IDLE.
  - IDLE: `tx_ready` = `tx_mode`, registered.
  - Accept on `tx_valid & tx_ready`. This loads the shift register, sets bit count 0 and enters LOW.
  - LOW: `cnt_out`=0, `sp_out`=current MSB; held HALF cycles, then enters HIGH.
  - HIGH: `cnt_out`=1, `sp_out` unchanged (CIA samples on this rising edge); held HALF cycles.
  - Leaving HIGH after bit 7 enters GAP; otherwise shift left and return to LOW.
  - GAP: `cnt_out`=1 for GAP cycles, then IDLE. `sp_out` keeps the last bit until the next byte starts.
- RX path (active only while `tx_mode`=0):
  - `cnt_in` is registered once; a falling edge (prev=1, now=0) samples `sp_in` into the shift register LSB and increments the 3-bit count.
  - 8th sample: `rx_data` ← assembled byte, `rx_valid` ← 1, count wraps to 0.
  - `rx_valid` clears on `rx_ready`.
  - Byte completes while `rx_valid`=1 and `rx_ready`=0: overwrite `rx_data`, pulse `rx_overrun`.
  - Byte completes in the same cycle as `rx_ready`: new byte loaded, `rx_valid` stays 1, no overrun.
  - Idle counter resets on each falling edge. If it reaches TIMEOUT with count≠0, the count and shift register clear. `rx_valid` and `rx_data` are untouched.
- While `tx_mode`=0: `cnt_out`=1, `sp_out`=1, TX FSM in IDLE.
- `tx_mode` 1→0 mid-byte aborts the byte: next cycle IDLE, `cnt_out`=1, byte lost.
- `tx_mode` 0→1 clears the RX count and shift register.
- `busy` is 1 in LOW/HIGH/GAP or while RX count≠0.

## Timing
- `tx_ready` falls the cycle after accept. `cnt_out` falls 1 cycle after accept.
- Byte duration: 16·HALF cycles of CNT activity, plus GAP.
- `tx_ready` re-asserts 16·HALF+GAP+1 cycles after accept, if `tx_mode` is still 1.
- `sp_out` changes only on the cycle `cnt_out` goes low; it is stable for the full LOW+HIGH pair.
- RX latency: `rx_valid` rises 2 cycles after the 8th `cnt_in` falling edge at the pins (1 sync + 1 register).
- Reset asserted mid-byte: all outputs take reset values immediately (asynchronous). The in-flight byte is dropped.

## Structure
- Package `cia_serial_pkg`:
  - `tx_state_t` enum (IDLE, LOW, HIGH, GAP).
  - Counter width function `clog2`-based for HALF, GAP and TIMEOUT.
  - Constant `BITS_PER_BYTE`=8.
- Sub-module `cia_sp_rx_shifter`: edge detect, shift, count, timeout and rx handshake. The top holds the TX FSM and muxes outputs on `tx_mode`.

## Test plan
- TX, HALF=4, GAP=16: send 0xA5.
  - `sp_out` per LOW phase = 1,0,1,0,0,1,0,1.
  - 8 `cnt_out` low pulses of 4 cycles each.
  - `tx_ready` back 81 cycles after accept.
  - A CIA in input mode reads SDR=0xA5 with ICR bit 3 set.
- RX: CIA in output mode with Timer A period 3 writes SDR=0x3C. `rx_data`=0x3C and `rx_valid`=1 two cycles after the 8th CNT fall; `rx_ready` clears it.
- Overrun: receive 0x11 then 0x22 without `rx_ready`. `rx_overrun` pulses once, `rx_data`=0x22. A repeat with `rx_ready` coincident with completion gives no pulse.
- Timeout: 3 CNT pulses, then TIMEOUT+1 idle cycles, then a full 0x81 byte. `rx_data`=0x81 and `busy`=0 after the timeout.
- Abort: drop `tx_mode` after 3 bits of 0xFF. Next cycle `cnt_out`=1, `sp_out`=1, `busy`=0; the CIA bit counter sees 3 falls only.
- Async reset mid-TX byte: `cnt_out`/`sp_out`=1 and `tx_ready`=0 during reset. After release, `tx_ready`=1 within 2 cycles when `tx_mode`=1.
